// File: rtl/cache_lookup_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cache_lookup_ctrl
//  Purpose  : Arbitrates I/D lookup requests, drives one tag-array read port,
//             issues a fill on miss and returns one response per request.
//  Options  : CACHE_STATS_EN enables saturating hit/miss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_lookup_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 5,
    parameter int WAY_W    = 3,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_ireq_valid,
    output logic                o_ireq_ready,
    input  logic [ADDR_W-1:0]   i_ireq_addr,
    input  logic                i_dreq_valid,
    output logic                o_dreq_ready,
    input  logic [ADDR_W-1:0]   i_dreq_addr,
    input  logic                i_dreq_we,
    output logic                o_tag_rd_en,
    output logic [INDEX_W-1:0]  o_tag_index,
    output logic [TAG_W-1:0]    o_tag_tag,
    input  logic                i_tag_hit,
    input  logic [WAY_W-1:0]    i_tag_way,
    output logic                o_fill_valid,
    input  logic                i_fill_ready,
    output logic                o_fill_dirty,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_src,
    output logic                o_rsp_hit,
    output logic [WAY_W-1:0]    o_rsp_way,
    output logic [TAG_W-1:0]    o_rsp_tag,
    output logic [INDEX_W-1:0]  o_rsp_index,
    output logic [OFFSET_W-1:0] o_rsp_offset,
    output logic [31:0]         o_hit_cnt,
    output logic [31:0]         o_miss_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_CMP    = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        r_state;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_src;
    logic              r_hit;
    logic [WAY_W-1:0]  r_way;

    logic w_idle;
    logic w_grant_i;
    logic w_grant_d;
    logic w_accept;
    logic w_rsp_hs;

    // rst_n in the grant keeps both readies low while reset is held
    assign w_idle    = rst_n && (r_state == S_IDLE);
    assign w_grant_i = w_idle & i_ireq_valid & (~i_dreq_valid | r_last_d);
    assign w_grant_d = w_idle & i_dreq_valid & (~i_ireq_valid | ~r_last_d);
    assign w_accept  = w_grant_i | w_grant_d;
    assign w_rsp_hs  = (r_state == S_RESP) & i_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) r_state <= S_LOOKUP;
                S_LOOKUP: r_state <= S_CMP;
                S_CMP:    r_state <= i_tag_hit ? S_RESP : S_FILL;
                S_FILL:   if (i_fill_ready) r_state <= S_RESP;
                S_RESP:   if (i_rsp_ready) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b1;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_src    <= 1'b0;
            r_hit    <= 1'b0;
            r_way    <= '0;
        end else begin
            if (w_accept) begin
                r_last_d <= w_grant_d;
                r_addr   <= w_grant_d ? i_dreq_addr : i_ireq_addr;
                r_we     <= w_grant_d & i_dreq_we;
                r_src    <= w_grant_d;
            end
            if (r_state == S_CMP) begin
                r_hit <= i_tag_hit;
                r_way <= i_tag_way;
            end
        end
    end

    assign o_ireq_ready = w_grant_i;
    assign o_dreq_ready = w_grant_d;
    assign o_tag_rd_en  = (r_state == S_LOOKUP);
    assign o_tag_index  = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign o_tag_tag    = r_addr[ADDR_W-1:OFFSET_W+INDEX_W];
    assign o_fill_valid = (r_state == S_FILL);
    assign o_fill_dirty = r_we;
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_src    = r_src;
    assign o_rsp_hit    = r_hit;
    assign o_rsp_way    = r_way;
    assign o_rsp_tag    = r_addr[ADDR_W-1:OFFSET_W+INDEX_W];
    assign o_rsp_index  = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign o_rsp_offset = r_addr[OFFSET_W-1:0];

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_rsp_hs) begin
            if (r_hit && (r_hit_cnt != 32'hFFFF_FFFF))
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (!r_hit && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`else
    assign o_hit_cnt  = 32'd0;
    assign o_miss_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
